// File: rtl/mux_stream_rr.sv
// N:1 valid/ready stream mux with fixed-select and round-robin modes and a single output register.
// Optional: define MUX_STREAM_CHAN_ID_EN to add an out_sel port tagging each word with its source.
module mux_stream_rr #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4,
    localparam int unsigned SEL_W   = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic [SEL_W-1:0]          select,
    input  logic                      mode,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
`ifdef MUX_STREAM_CHAN_ID_EN
    output logic [SEL_W-1:0]          out_sel,
`endif
    input  logic                      out_ready
);

    logic [SEL_W-1:0] r_ptr;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;

    logic             w_load;
    logic             w_take;
    logic             w_gnt_vld;
    logic [SEL_W-1:0] w_gnt;
    logic [SEL_W-1:0] w_idx;
    logic [WIDTH-1:0] w_gnt_data;

    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt     = '0;
        w_idx     = '0;
        if (!mode) begin
            // An out-of-range select matches no k, so it yields no grant.
            for (int k = 0; k < CHANNELS; k++) begin
                if (select == SEL_W'(k) && in_valid[k]) begin
                    w_gnt_vld = 1'b1;
                    w_gnt     = SEL_W'(k);
                end
            end
        end else begin
            // Walk the search order backwards so the earliest candidate after r_ptr wins.
            for (int i = CHANNELS; i >= 1; i--) begin
                w_idx = SEL_W'((int'(r_ptr) + i) % CHANNELS);
                if (in_valid[w_idx]) begin
                    w_gnt_vld = 1'b1;
                    w_gnt     = w_idx;
                end
            end
        end
    end

    assign w_load = !r_valid || out_ready;
    assign w_take = !rst && w_load && w_gnt_vld;

    always_comb begin
        in_ready   = '0;
        w_gnt_data = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            in_ready[k] = w_take && (w_gnt == SEL_W'(k));
            if (w_gnt == SEL_W'(k)) begin
                w_gnt_data = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ptr   <= SEL_W'(CHANNELS - 1);
        end else if (w_load) begin
            if (w_gnt_vld) begin
                r_valid <= 1'b1;
                r_data  <= w_gnt_data;
                r_ptr   <= w_gnt;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

`ifdef MUX_STREAM_CHAN_ID_EN
    logic [SEL_W-1:0] r_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel <= '0;
        end else if (w_load && w_gnt_vld) begin
            r_sel <= w_gnt;
        end
    end

    assign out_sel = r_sel;
`endif

    assign out_data  = r_data;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_mux_stream_rr.sv
// Self-checking bench for mux_stream_rr: directed scenarios plus a randomized run against a
// cycle-level reference model and per-channel ordering scoreboard.
module tb_mux_stream_rr;

    localparam int unsigned W  = 8;
    localparam int unsigned C  = 4;
    localparam int unsigned SW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [C*W-1:0] in_data;
    logic [C-1:0]   in_valid;
    logic [C-1:0]   in_ready;
    logic [SW-1:0]  select;
    logic           mode;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready;
`ifdef MUX_STREAM_CHAN_ID_EN
    logic [SW-1:0]  out_sel;
`endif

    mux_stream_rr #(
        .WIDTH   (W),
        .CHANNELS(C)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .select   (select),
        .mode     (mode),
        .out_data (out_data),
        .out_valid(out_valid),
`ifdef MUX_STREAM_CHAN_ID_EN
        .out_sel  (out_sel),
`endif
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int           m_ptr;
    logic         m_ov;
    logic [W-1:0] m_od;
    int           m_sel;
    bit           m_gv;
    int           m_g;
    logic [C-1:0] m_rdy;

    // Random-run producer/consumer bookkeeping
    logic [C-1:0] pend;
    logic [C-1:0] hs;
    logic [5:0]   seq     [C];
    logic [5:0]   exp_seq [C];
    int           ch;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_eval();
        bit load;
        int s;
        load  = !m_ov || out_ready;
        m_gv  = 1'b0;
        m_g   = 0;
        m_rdy = '0;
        if (!rst) begin
            if (mode == 1'b0) begin
                s = int'(select);
                if (s < int'(C) && in_valid[s]) begin
                    m_gv = 1'b1;
                    m_g  = s;
                end
            end else begin
                for (int i = 1; i <= int'(C); i++) begin
                    int k;
                    k = (m_ptr + i) % int'(C);
                    if (!m_gv && in_valid[k]) begin
                        m_gv = 1'b1;
                        m_g  = k;
                    end
                end
            end
            if (load && m_gv) m_rdy[m_g] = 1'b1;
        end
    endtask

    // One clock: check in_ready before the edge, advance the model, check outputs after it.
    task automatic step(input string tag);
        #1;
        model_eval();
        check({tag, "_rdy"}, 32'(in_ready), 32'(m_rdy));
        @(posedge clk);
        if (rst) begin
            m_ov  = 1'b0;
            m_od  = '0;
            m_ptr = C - 1;
            m_sel = 0;
        end else if (!m_ov || out_ready) begin
            if (m_gv) begin
                m_ov  = 1'b1;
                m_od  = in_data[m_g*W +: W];
                m_ptr = m_g;
                m_sel = m_g;
            end else begin
                m_ov = 1'b0;
            end
        end
        #1;
        check({tag, "_ov"}, 32'(out_valid), 32'(m_ov));
        check({tag, "_od"}, 32'(out_data), 32'(m_od));
`ifdef MUX_STREAM_CHAN_ID_EN
        check({tag, "_sel"}, 32'(out_sel), 32'(m_sel));
`endif
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = '1;
        mode      = 1'b1;
        select    = '0;
        out_ready = 1'b1;
        in_data   = 32'h1312_1110;

        // Reset with every channel valid
        repeat (2) begin
            step("reset");
            check("reset_ov", 32'(out_valid), 32'd0);
            check("reset_od", 32'(out_data), 32'd0);
            check("reset_rdy", 32'(in_ready), 32'd0);
        end

        // Round-robin fairness, first grant to channel 0
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step("rr");
            check("rr_seq", 32'(out_data), 32'h10 + 32'(i % 4));
            check("rr_ov", 32'(out_valid), 32'd1);
        end

        // Fixed select on channel 2
        mode             = 1'b0;
        select           = 2'd2;
        in_data[16 +: 8] = 8'hA5;
        #1;
        check("fix_rdy_pre", 32'(in_ready), 32'b0100);
        repeat (2) begin
            step("fix");
            check("fix_od", 32'(out_data), 32'hA5);
            check("fix_ov", 32'(out_valid), 32'd1);
            check("fix_rdy", 32'(in_ready), 32'b0100);
        end

        // Backpressure holds 0x11 then releases 0x12
        rst     = 1'b1;
        mode    = 1'b1;
        in_data = 32'h1312_1110;
        step("bp_rst");
        rst = 1'b0;
        step("bp");
        step("bp");
        check("bp_pre", 32'(out_data), 32'h11);
        out_ready = 1'b0;
        repeat (3) begin
            step("bp_hold");
            check("bp_od", 32'(out_data), 32'h11);
            check("bp_ov", 32'(out_valid), 32'd1);
            check("bp_rdy", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        step("bp_rel");
        check("bp_rel_od", 32'(out_data), 32'h12);

        // Reset while a word is registered
        rst = 1'b1;
        step("mid_rst");
        check("mid_rst_ov", 32'(out_valid), 32'd0);
        check("mid_rst_rdy", 32'(in_ready), 32'd0);

        // Sparse wrap from ptr=3 with channels 1 and 3
        rst      = 1'b0;
        in_valid = 4'b1010;
        in_data  = 32'h2322_2120;
        step("sparse");
        check("sparse_a", 32'(out_data), 32'h21);
        step("sparse");
        check("sparse_b", 32'(out_data), 32'h23);
        step("sparse");
        check("sparse_c", 32'(out_data), 32'h21);
        in_valid = '0;
        step("drain");
        check("drain_ov", 32'(out_valid), 32'd0);

        // Only the last-granted channel valid: regranted back to back
        in_valid = 4'b0010;
        step("regrant");
        check("regrant_a", 32'(out_valid), 32'd1);
        step("regrant");
        check("regrant_b", 32'(out_valid), 32'd1);
        check("regrant_od", 32'(out_data), 32'h21);

        // Randomized run with per-channel sequence tags {channel, seq}
        in_valid = '0;
        rst      = 1'b1;
        step("rnd_rst");
        rst  = 1'b0;
        pend = '0;
        for (int k = 0; k < int'(C); k++) begin
            seq[k]     = '0;
            exp_seq[k] = '0;
        end
        repeat (1000) begin
            for (int k = 0; k < int'(C); k++) begin
                if (!pend[k] && $urandom_range(0, 1) == 1) begin
                    pend[k]          = 1'b1;
                    in_data[k*W +: W] = {2'(k), seq[k]};
                end
            end
            in_valid  = pend;
            mode      = 1'($urandom_range(0, 1));
            select    = SW'($urandom_range(0, C - 1));
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            hs = in_valid & in_ready;
            if (out_valid && out_ready) begin
                ch = int'(out_data[7:6]);
                check("rnd_order", 32'(out_data[5:0]), 32'(exp_seq[ch]));
                exp_seq[ch] = exp_seq[ch] + 6'd1;
            end
            step("rnd");
            for (int k = 0; k < int'(C); k++) begin
                if (hs[k]) begin
                    pend[k] = 1'b0;
                    seq[k]  = seq[k] + 6'd1;
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_stream_rr.md
Name: mux_stream_rr

Overview:
- Parametrised N:1 streaming multiplexer. Successor to the 2:1 combinational mux; selects one of CHANNELS valid/ready input streams into a single registered output stream.
- Two modes: fixed select (software-steered) and round-robin (fair arbitration among valid channels).
- Sits between multiple producers and one shared consumer. Output is a single register stage with full-throughput backpressure.

Parameters:
- WIDTH, 8, data bits per channel (>=1).
- CHANNELS, 4, number of input channels (>=2).
- SEL_W (localparam), $clog2(CHANNELS), select / pointer width.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_data  input  CHANNELS*WIDTH  packed inputs; channel k occupies bits [k*WIDTH +: WIDTH]
- in_valid  input  CHANNELS  per-channel valid
- in_ready  output  CHANNELS  per-channel ready (combinational)
- select  input  SEL_W  channel index used in mode 0
- mode  input  1  0 = fixed select, 1 = round-robin
- out_data  output  WIDTH  registered output data
- out_valid  output  1  registered output valid
- out_ready  input  1  consumer ready

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: out_valid=0, out_data=0, internal last-grant pointer ptr=CHANNELS-1, so the first round-robin search starts at channel 0.
- load = !out_valid || out_ready. This is an internal combinational signal, true when the output register can accept a new word this cycle.
- Grant g, evaluated combinationally every cycle:
  - mode 0: g = select, valid only if select < CHANNELS and in_valid[select]=1.
  - mode 1: g = first k with in_valid[k]=1, searching ptr+1, ptr+2, … wrapping modulo CHANNELS, ending at ptr. ptr itself is checked last.
  - No candidate means no grant.
- in_ready[k] = load && grant exists && k==g. All other in_ready bits are 0. At most one in_ready is high per cycle.
- Transfer at the clock edge when load and a grant exist:
  - out_data <= in_data[g]; out_valid <= 1.
  - In mode 1, ptr <= g. In mode 0, ptr <= g as well, so a later switch to round-robin continues fairly.
- When load is true and no grant exists: out_valid <= 0; out_data holds its last value.
- When load is false (out_valid=1, out_ready=0): out_data, out_valid and ptr hold. All in_ready bits are 0.
- Latency: 1 cycle from input handshake to out_valid. Throughput: 1 word per cycle while out_ready=1.
- Output stability: out_data/out_valid never change while out_valid=1 and out_ready=0.
- Boundary cases:
  - mode or select change takes effect on the next grant evaluation. An already-registered word is unaffected.
  - select >= CHANNELS (non-power-of-2 CHANNELS) gives no grant and all in_ready=0.
  - All channels valid in mode 1: strict rotation 0,1,2,…,CHANNELS-1,0.
  - Only channel ptr valid: it is re-granted with no idle cycle.
  - rst asserted mid-transfer: the registered word is discarded (out_valid=0 next cycle). No in_ready is asserted in the reset cycle. ptr returns to CHANNELS-1.
- Input data on non-granted channels is ignored. Producers must hold in_data/in_valid until their in_ready handshake completes.

Optional Feature:
- Macro: MUX_STREAM_CHAN_ID_EN.
- Defined:
  - Adds output port out_sel [SEL_W]. It is registered alongside out_data and loaded with g on each transfer.
  - Reset value 0; holds under backpressure like out_data.
- Not defined: no out_sel port and no associated register. All other behaviour is identical.

Test Plan:
- Reset: assert rst for 2 cycles with all in_valid=1 -> out_valid=0, out_data=0, in_ready=0 throughout. The first grant after release in mode 1 goes to channel 0.
- Fixed select: WIDTH=8, CHANNELS=4, mode=0, select=2, in_data ch2=0xA5, all valid, out_ready=1 -> in_ready=4'b0100. The next cycle gives out_data=0xA5, out_valid=1. Channels 0, 1 and 3 never receive ready.
- Round-robin fairness: mode=1, all four valid continuously, data ch k = 0x10+k, out_ready=1 -> output sequence 0x10,0x11,0x12,0x13,0x10 on consecutive cycles.
- Backpressure: out_valid=1 with 0x11, out_ready=0 for 3 cycles -> out_data stays 0x11 and all in_ready=0. After out_ready=1, the next word (0x12) appears the following cycle.
- Sparse/wrap: mode=1, ptr=3, only ch1 and ch3 valid -> grant ch1, then ch3, then ch1. Then drop all valid -> out_valid falls to 0 the cycle after the last accept.
- Random regression (with and without MUX_STREAM_CHAN_ID_EN): 1000 cycles of random valid/select/mode/out_ready checked against a reference model. Checks cover no data loss or duplication, in-order per channel, and out_sel matching the source channel when enabled.
